// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder for the CPU data port
//
// Accepts one load/store at a time on a valid/ready handshake and serves it
// LATENCY cycles later with a one-cycle resp_valid pulse. Little-endian byte
// storage of 2**ADDR_WIDTH bytes; word or zero-extended byte accesses.
//
// Ports:
//   clk         CPU clock, rising edge
//   rst         synchronous reset, active low
//   req_valid   request present
//   req_ready   responder can accept this cycle (registered)
//   req_we      1 = store, 0 = load
//   req_atype   1 = byte access, 0 = word access
//   req_addr    byte address, only [ADDR_WIDTH-1:0] used
//   req_wdata   store data, byte store uses [7:0]
//   resp_valid  one-cycle response pulse
//   resp_rdata  load data, 0 for stores and errors; held until next response
//   resp_err    misaligned word access; held until next response

module dmem_responder #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 17,
   parameter int LATENCY    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic             req_atype,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0] LAST = 4'(LATENCY - 1);

   state_t                state;
   logic [3:0]            cnt;
   logic                  we_q;
   logic                  atype_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [WIDTH-1:0]      wdata_q;

   logic [7:0]            mem [0:(1<<ADDR_WIDTH)-1];

   logic                  accept;
   logic                  enter_resp;
   logic                  op_we;
   logic                  op_atype;
   logic [ADDR_WIDTH-1:0] op_addr;
   logic [WIDTH-1:0]      op_wdata;
   logic                  misaligned;
   logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
   logic [WIDTH-1:0]      load_data;

   // High address bits are discarded: addresses wrap modulo the storage size.
   logic                  unused_addr_hi;
   assign unused_addr_hi = ^req_addr[WIDTH-1:ADDR_WIDTH];

   assign accept = (state == ST_IDLE) && req_valid && req_ready;

   // With LATENCY==1 the access happens on the accept edge itself, so the
   // operands come straight from the request inputs instead of the latches.
   always_comb begin
      op_we    = we_q;
      op_atype = atype_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
      if (LATENCY == 1) begin
         op_we    = req_we;
         op_atype = req_atype;
         op_addr  = req_addr[ADDR_WIDTH-1:0];
         op_wdata = req_wdata;
      end
   end

   always_comb begin
      enter_resp = 1'b0;
      if (LATENCY == 1)
         enter_resp = accept;
      else
         enter_resp = (state == ST_WAIT) && (cnt == LAST);
   end

   assign misaligned = !op_atype && (op_addr[1:0] != 2'b00);

   assign a0 = op_addr;
   assign a1 = op_addr + ADDR_WIDTH'(1);
   assign a2 = op_addr + ADDR_WIDTH'(2);
   assign a3 = op_addr + ADDR_WIDTH'(3);

   always_comb begin
      load_data = '0;
      if (op_atype)
         load_data = {{(WIDTH-8){1'b0}}, mem[a0]};
      else
         load_data = {mem[a3], mem[a2], mem[a1], mem[a0]};
   end

   // Storage is never reset; a reset on the commit edge suppresses the write.
   always_ff @(posedge clk) begin
      if (rst && enter_resp && op_we && !misaligned) begin
         if (op_atype) begin
            mem[a0] <= op_wdata[7:0];
         end else begin
            mem[a0] <= op_wdata[7:0];
            mem[a1] <= op_wdata[15:8];
            mem[a2] <= op_wdata[23:16];
            mem[a3] <= op_wdata[31:24];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         cnt        <= 4'd0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  we_q      <= req_we;
                  atype_q   <= req_atype;
                  addr_q    <= req_addr[ADDR_WIDTH-1:0];
                  wdata_q   <= req_wdata;
                  req_ready <= 1'b0;
                  if (LATENCY == 1) begin
                     state <= ST_RESP;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= 4'd1;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt == LAST)
                  state <= ST_RESP;
               else
                  cnt <= cnt + 4'd1;
            end
            ST_RESP: begin
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               cnt        <= 4'd0;
               state      <= ST_IDLE;
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
            end
         endcase

         if (enter_resp) begin
            resp_valid <= 1'b1;
            resp_err   <= misaligned;
            resp_rdata <= (misaligned || op_we) ? '0 : load_data;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder

module tb_dmem_responder;

   localparam int LATENCY = 2;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic        req_atype;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;

   int          idx;
   int          got;
   int          acc[3];
   logic [31:0] b2b_addr[3];
   logic        b2b_atype[3];
   logic [31:0] b2b_exp[3];
   exp_t        e;

   dmem_responder #(.WIDTH(32), .ADDR_WIDTH(17), .LATENCY(LATENCY)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_atype  (req_atype),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the response cycle.
   task automatic do_req(input string tag, input logic we, input logic atype,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] er, input logic ee);
      int   k;
      exp_t x;
      k = 0;
      while (!req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_atype = atype;
      req_addr  = addr;
      req_wdata = wdata;
      sb.push_back('{er, ee});
      @(negedge clk);
      // scramble inputs to prove the request was latched
      req_valid = 1'b0;
      req_we    = ~we;
      req_atype = ~atype;
      req_addr  = $urandom;
      req_wdata = $urandom;
      chk({tag, "_busy"}, 32'(req_ready), 32'd0);
      k = 1;
      while (!resp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_lat"}, 32'(k), 32'(LATENCY));
      x = sb.pop_front();
      chk({tag, "_rdata"}, resp_rdata, x.rdata);
      chk({tag, "_err"}, 32'(resp_err), 32'(x.err));
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
      chk({tag, "_idle"}, 32'(req_ready), 32'd1);
      chk({tag, "_hold"}, resp_rdata, x.rdata);
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_atype = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);

      do_req("wst100", 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
      do_req("wld100", 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);

      do_req("bst101", 1'b1, 1'b1, 32'h101, 32'hFFFFFF5A, 32'h0, 1'b0);
      do_req("wld100b", 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEAD5AEF, 1'b0);
      do_req("bld103", 1'b0, 1'b1, 32'h103, 32'h0, 32'h000000DE, 1'b0);

      do_req("mst102", 1'b1, 1'b0, 32'h102, 32'h11111111, 32'h0, 1'b1);
      do_req("wld100c", 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEAD5AEF, 1'b0);
      do_req("mld101", 1'b0, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1);

      // abandoned store: reset lands on the edge that would enter RESP
      do_req("pre200", 1'b1, 1'b0, 32'h200, 32'h12345678, 32'h0, 1'b0);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_atype = 1'b0;
      req_addr  = 32'h200;
      req_wdata = 32'hCAFEF00D;
      @(negedge clk);
      req_valid = 1'b0;
      rst       = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("abort_valid0", 32'(resp_valid), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd1);
      chk("abort_rdata", resp_rdata, 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("abort_novalid", 32'(resp_valid), 32'd0);
      end
      do_req("wld200", 1'b0, 1'b0, 32'h200, 32'h0, 32'h12345678, 1'b0);

      // back-to-back loads with req_valid held high, including wrapped addresses
      b2b_addr[0] = 32'h00000100; b2b_atype[0] = 1'b0; b2b_exp[0] = 32'hDEAD5AEF;
      b2b_addr[1] = 32'h00020100; b2b_atype[1] = 1'b0; b2b_exp[1] = 32'hDEAD5AEF;
      b2b_addr[2] = 32'h00020103; b2b_atype[2] = 1'b1; b2b_exp[2] = 32'h000000DE;
      idx = 0;
      got = 0;
      for (int c = 0; c < 20; c++) begin
         if (resp_valid) begin
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("b2b_rdata", resp_rdata, e.rdata);
               chk("b2b_err", 32'(resp_err), 32'(e.err));
            end else begin
               chk("b2b_extra_resp", 32'(resp_valid), 32'd0);
            end
            got++;
         end
         if (req_ready) begin
            if (idx < 3) begin
               req_valid = 1'b1;
               req_we    = 1'b0;
               req_atype = b2b_atype[idx];
               req_addr  = b2b_addr[idx];
               req_wdata = $urandom;
               sb.push_back('{b2b_exp[idx], 1'b0});
               acc[idx] = c;
               idx++;
            end else begin
               req_valid = 1'b0;
            end
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("b2b_accepts", 32'(idx), 32'd3);
      chk("b2b_resps", 32'(got), 32'd3);
      chk("b2b_gap01", 32'(acc[1] - acc[0]), 32'(LATENCY + 1));
      chk("b2b_gap12", 32'(acc[2] - acc[1]), 32'(LATENCY + 1));
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
